riscv_v_bw_reduct_acc: RTL and testbench
========================================

// Module: riscv_v_bw_reduct_acc
// PURPOSE
//  Multi-beat accumulator for vector bitwise reductions (vredand/vredor/vredxor). Sits downstream of the
//  byte-sliced bitwise units: consumes per-beat ALU data with byte valids over a valid/ready stream and
//  folds every active element, plus the vs1[0] seed, into one scalar of width osize.
//  Returns the scalar to writeback over a valid/ready handshake. One reduction in flight at a time.
// PARAMETERS
//  DATA_WIDTH  128  beat width in bits; multiple of 64
//  CNT_WIDTH   8    width of beat counter / num_beats
// PORTS
//  clk            in   1             clock
//  rst_n          in   1             synchronous reset, active low
//  start_valid    in   1             new reduction request
//  start_ready    out  1             accepting request (IDLE only)
//  start_op       in   2             bw_op_t: 00 AND, 01 OR, 10 XOR, 11 reserved (treated as XOR)
//  start_osize    in   4             osize_vector_t one-hot: [0]=8b [1]=16b [2]=32b [3]=64b
//  start_beats    in   CNT_WIDTH     number of data beats expected (0 allowed)
//  start_seed     in   64            scalar seed (vs1[0]); only low osize bits used
//  in_valid       in   1             data beat valid
//  in_ready       out  1             accepting beat (ACC only)
//  in_data        in   DATA_WIDTH    beat data
//  in_byte_valid  in   DATA_WIDTH/8  per-byte active mask (vl/mask/tail already applied)
//  in_last        in   1             producer marks final beat
//  out_valid      out  1             scalar result valid
//  out_ready      in   1             writeback accepts result
//  out_data       out  64            result, zero-extended above osize
//  out_err        out  1             beat-count/in_last mismatch of current result
//  busy           out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 sampled at clk edge): state=IDLE, acc=0, cnt=0, op/osize regs=0, out_valid=0,
//    out_data=0, out_err=0, busy=0, in_ready=0, start_ready=1 after reset releases.
//  - FSM IDLE -> ACC -> DONE -> IDLE. Transfers occur when valid&ready at clk edge.
//  - IDLE: start_ready=1. On start: latch op, osize, beats; acc<=seed masked to osize; cnt<=0; err<=0;
//    next=ACC, or DONE directly if start_beats==0 (out_data=masked seed).
//  - ACC: in_ready=1. Per accepted beat: bytes with in_byte_valid=0 replaced by identity byte
//    (0xFF for AND, 0x00 for OR/XOR); beat folded to one osize element by binary tree of op over
//    DATA_WIDTH/osize lanes; acc <= acc op fold; cnt<=cnt+1. Throughput 1 beat/cycle, no bubbles.
//  - Final beat = (cnt==beats-1) OR in_last. On final beat next=DONE; err<=1 if (cnt==beats-1)!=in_last.
//  - DONE: out_valid=1, out_data={zeros, acc[osize-1:0]}, out_err=err; holds stable until out_ready;
//    on out_ready next=IDLE (start not accepted in same cycle; 1 bubble between reductions).
//  - All-bytes-invalid beat: contributes identity, still counts as a beat.
//  - Counter does not wrap: beats<=2^CNT_WIDTH-1 by construction.
//  - start_valid in ACC/DONE ignored (start_ready=0); in_valid in IDLE/DONE ignored (in_ready=0).
//  - Reset mid-operation: abandons reduction, no out_valid emitted, all state to reset values.
//  - Latency: result valid 1 cycle after final beat accepted.
// STRUCTURE
//  - riscv_v_pkg: bw_op_t enum, osize_vector_t, BW_IDENT_AND=8'hFF / BW_IDENT_ORXOR=8'h00 constants,
//    function osize_mask(osize) returning 64b mask.
//  - Sub-module riscv_v_bw_fold (combinational): identity substitution + log2 lane fold of one beat to
//    a 64b value valid in low osize bits. Accumulator module holds FSM, counter, acc register.
// TESTING
//  - XOR,16b, seed=0x0001, 1 beat 128b all valid, lanes 0x0001..0x0008 -> out_data=0x0009, err=0.
//  - AND,8b, seed=0xFF, 2 beats; beat1 byte3=0x0F, other bytes 0xFF; beat2 byte_valid=0 except byte0=0xF3 -> 0x03.
//  - OR,64b, start_beats=0, seed=0xDEAD_BEEF_0000_0001 -> DONE next cycle, out=seed, in_ready never 1.
//  - XOR,32b, beats=3, in_last on beat 2 -> DONE after 2nd beat, out_err=1; in_last absent on beat 3 also err=1.
//  - Back-pressure: out_ready=0 for 5 cycles -> out_valid/out_data stable, start_ready=0; then accept, IDLE.
//  - rst_n=0 after 1 of 4 beats -> out_valid never asserts; new start after reset yields seed-only result.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared types and helpers for the vector bitwise reduction path.
// Ops, one-hot element sizes, identity bytes and the osize mask.
package riscv_v_pkg;

    typedef enum logic [1:0] {
        BW_AND  = 2'b00,
        BW_OR   = 2'b01,
        BW_XOR  = 2'b10,
        BW_RSVD = 2'b11
    } bw_op_t;

    // One-hot: [0]=8b [1]=16b [2]=32b [3]=64b
    typedef logic [3:0] osize_vector_t;

    localparam logic [7:0] BW_IDENT_AND   = 8'hFF;
    localparam logic [7:0] BW_IDENT_ORXOR = 8'h00;

    function automatic logic [63:0] osize_mask(osize_vector_t osize);
        logic [63:0] m;
        if (osize[0])      m = 64'h0000_0000_0000_00FF;
        else if (osize[1]) m = 64'h0000_0000_0000_FFFF;
        else if (osize[2]) m = 64'h0000_0000_FFFF_FFFF;
        else               m = 64'hFFFF_FFFF_FFFF_FFFF;
        return m;
    endfunction

    // Reserved encoding behaves as XOR.
    function automatic logic [63:0] bw_apply(bw_op_t op,
                                             logic [63:0] a,
                                             logic [63:0] b);
        logic [63:0] r;
        case (op)
            BW_AND:  r = a & b;
            BW_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_v_bw_fold.sv
// Folds one beat to a single osize element: inactive bytes become the
// op identity, then 64b chunks and halves are combined with the op.
module riscv_v_bw_fold
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  bw_op_t                    op_i,
    input  osize_vector_t             osize_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic [DATA_WIDTH/8-1:0]   byte_valid_i,
    output logic [63:0]               fold_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int NW = DATA_WIDTH / 64;

    logic [7:0]            ident;
    logic [DATA_WIDTH-1:0] subst;
    logic [63:0]           r64;
    logic [63:0]           t32;
    logic [63:0]           t16;
    logic [63:0]           t8;

    always_comb begin
        ident = (op_i == BW_AND) ? BW_IDENT_AND : BW_IDENT_ORXOR;
        subst = '0;
        for (int b = 0; b < NB; b++) begin
            subst[b*8 +: 8] = byte_valid_i[b] ? data_i[b*8 +: 8] : ident;
        end
    end

    always_comb begin
        r64 = subst[63:0];
        for (int w = 1; w < NW; w++) begin
            r64 = bw_apply(op_i, r64, subst[w*64 +: 64]);
        end
    end

    always_comb begin
        t32 = bw_apply(op_i, {32'h0, r64[63:32]}, {32'h0, r64[31:0]});
        t16 = bw_apply(op_i, {48'h0, t32[31:16]}, {48'h0, t32[15:0]});
        t8  = bw_apply(op_i, {56'h0, t16[15:8]},  {56'h0, t16[7:0]});
    end

    always_comb begin
        if (osize_i[0])      fold_o = {56'h0, t8[7:0]};
        else if (osize_i[1]) fold_o = {48'h0, t16[15:0]};
        else if (osize_i[2]) fold_o = {32'h0, t32[31:0]};
        else                 fold_o = r64;
    end

endmodule

// File: rtl/riscv_v_bw_reduct_acc.sv
// Multi-beat accumulator for vredand/vredor/vredxor: folds streamed beats
// plus the vs1[0] seed into one scalar and hands it to writeback.
module riscv_v_bw_reduct_acc
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [1:0]              start_op,
    input  logic [3:0]              start_osize,
    input  logic [CNT_WIDTH-1:0]    start_beats,
    input  logic [63:0]             start_seed,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_byte_valid,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic                    out_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    bw_op_t                 op_q, op_d;
    osize_vector_t          osize_q, osize_d;
    logic [CNT_WIDTH-1:0]   beats_q, beats_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [63:0]            acc_q, acc_d;
    logic                   err_q, err_d;

    logic [63:0]            fold;
    logic                   cnt_last;

    riscv_v_bw_fold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fold (
        .op_i         (op_q),
        .osize_i      (osize_q),
        .data_i       (in_data),
        .byte_valid_i (in_byte_valid),
        .fold_o       (fold)
    );

    assign cnt_last = (cnt_q == beats_q - CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        osize_d = osize_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    op_d    = bw_op_t'(start_op);
                    osize_d = start_osize;
                    beats_d = start_beats;
                    acc_d   = start_seed & osize_mask(start_osize);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (start_beats == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = bw_apply(op_q, acc_q, fold) & osize_mask(osize_q);
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_last || in_last) begin
                        state_d = S_DONE;
                        err_d   = (cnt_last != in_last);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= BW_AND;
            osize_q <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            osize_q <= osize_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        start_ready = (state_q == S_IDLE);
        in_ready    = (state_q == S_ACC);
        out_valid   = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        out_data    = out_valid ? acc_q : 64'h0;
        out_err     = out_valid & err_q;
    end

endmodule

// File: tb/tb_riscv_v_bw_reduct_acc.sv
// Directed bench for the bitwise reduction accumulator.
module tb_riscv_v_bw_reduct_acc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [1:0]   start_op;
    logic [3:0]   start_osize;
    logic [7:0]   start_beats;
    logic [63:0]  start_seed;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_byte_valid;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_err;
    logic         busy;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    riscv_v_bw_reduct_acc #(
        .DATA_WIDTH (128),
        .CNT_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .start_op      (start_op),
        .start_osize   (start_osize),
        .start_beats   (start_beats),
        .start_seed    (start_seed),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_byte_valid (in_byte_valid),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] op, input logic [3:0] osz,
                            input logic [7:0] nb, input logic [63:0] seed);
        start_valid = 1'b1;
        start_op    = op;
        start_osize = osz;
        start_beats = nb;
        start_seed  = seed;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [127:0] d, input logic [15:0] bv,
                           input logic last);
        in_valid      = 1'b1;
        in_data       = d;
        in_byte_valid = bv;
        in_last       = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        start_op = 2'b00;
        start_osize = 4'b0001;
        start_beats = 8'd0;
        start_seed = 64'h0;
        in_valid = 1'b0;
        in_data = '0;
        in_byte_valid = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);

        // XOR 16b, lanes 1..8, seed 1
        do_start(2'b10, 4'b0010, 8'd1, 64'h0001);
        check("xor_in_ready", 64'(in_ready), 64'd1);
        check("xor_start_ready", 64'(start_ready), 64'd0);
        do_beat({16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1},
                16'hFFFF, 1'b1);
        check("xor_out_valid", 64'(out_valid), 64'd1);
        check("xor_out_data", out_data, 64'h0009);
        check("xor_out_err", 64'(out_err), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("xor_back_idle", 64'(start_ready), 64'd1);
        check("xor_ov_drop", 64'(out_valid), 64'd0);

        // AND 8b with identity substitution on invalid bytes
        do_start(2'b00, 4'b0001, 8'd2, 64'hFF);
        do_beat({{12{8'hFF}}, 8'h0F, {3{8'hFF}}}, 16'hFFFF, 1'b0);
        check("and_mid_busy", 64'(out_valid), 64'd0);
        do_beat({{15{8'h00}}, 8'hF3}, 16'h0001, 1'b1);
        check("and_out_data", out_data, 64'h03);
        check("and_out_err", 64'(out_err), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // OR 64b, zero beats: seed passes straight through
        do_start(2'b01, 4'b1000, 8'd0, 64'hDEAD_BEEF_0000_0001);
        check("or0_out_valid", 64'(out_valid), 64'd1);
        check("or0_in_ready", 64'(in_ready), 64'd0);
        check("or0_out_data", out_data, 64'hDEAD_BEEF_0000_0001);
        do_beat({2{64'hFFFF_FFFF_FFFF_FFFF}}, 16'hFFFF, 1'b1);
        check("or0_ignore_in", out_data, 64'hDEAD_BEEF_0000_0001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // XOR 32b, beats=3 but in_last on beat 2: early end with err
        do_start(2'b10, 4'b0100, 8'd3, 64'h0);
        do_beat({32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFFF, 1'b0);
        do_beat({32'h10, 32'h0, 32'h0, 32'h0}, 16'hFFFF, 1'b1);
        check("early_out_valid", 64'(out_valid), 64'd1);
        check("early_out_data", out_data, 64'h14);
        check("early_out_err", 64'(out_err), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // XOR 32b, beats=3 with no in_last: err; then back-pressure
        do_start(2'b10, 4'b0100, 8'd3, 64'hFFFF_FFFF_A5A5_A5A5);
        do_beat('0, 16'hFFFF, 1'b0);
        do_beat('0, 16'hFFFF, 1'b0);
        do_beat('0, 16'hFFFF, 1'b0);
        check("nolast_out_data", out_data, 64'hA5A5_A5A5);
        check("nolast_out_err", 64'(out_err), 64'd1);
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, 64'hA5A5_A5A5);
            check("bp_start_ready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_idle_sr", 64'(start_ready), 64'd1);

        // Reset after 1 of 4 beats abandons the reduction
        do_start(2'b01, 4'b0001, 8'd4, 64'h11);
        do_beat({16{8'h5A}}, 16'hFFFF, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_ov", 64'(out_valid), 64'd0);
            check("rst_mid_busy", 64'(busy), 64'd0);
            tick();
        end
        do_start(2'b01, 4'b0001, 8'd0, 64'h1234_5622);
        check("post_rst_data", out_data, 64'h22);
        check("post_rst_err", 64'(out_err), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
